// File: rtl/xunit_sha2_rounds_pkg.sv
// xunit_sha2_rounds_pkg: shared FSM encoding, SHA-256/SHA-512 rotation amounts, DATA_W legality check
package xunit_sha2_rounds_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LOAD, S_ROUND, S_FF, S_DONE} state_e;
  localparam int ROT256 [6] = '{2, 13, 22, 6, 11, 25};
  localparam int ROT512 [6] = '{28, 34, 39, 14, 18, 41};
  // idx 0..2 are the Sigma0 rotations, 3..5 the Sigma1 rotations
  function automatic int rot_amt(input int data_w, input int idx);
    return data_w == 64 ? ROT512[idx] : ROT256[idx];
  endfunction
  function automatic bit legal_data_w(input int w);
    return w == 32 || w == 64;
  endfunction
endpackage

// File: rtl/xunit_sha2_rounds_if.sv
// xunit_sha2_rounds_if: run/done handshake, data words and config bundle of the SHA-2 rounds unit
//   din[0..7] initial state a..h, din[8] W_t, din[9] K_t; dout[0..7] state a..h
//   master drives run/din/config_*, slave (the unit) drives done/dout
interface xunit_sha2_rounds_if #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8,
  parameter int ROUND_W = 7
) ();
  logic               run;
  logic               done;
  logic [DATA_W-1:0]  din  [10];
  logic [DATA_W-1:0]  dout [8];
  logic [DELAY_W-1:0] config_delay;
  logic [ROUND_W-1:0] config_rounds;
  logic               config_feedfwd;
  modport master (output run, din, config_delay, config_rounds, config_feedfwd, input done, dout);
  modport slave  (input run, din, config_delay, config_rounds, config_feedfwd, output done, dout);
endinterface

// File: rtl/xunit_sha2_rounds_round_comb.sv
// xsha2_round_comb: one combinational SHA-2 compression round
//   s_i a..h, w W_t, k K_t in; s_o next a..h out
module xsha2_round_comb import xunit_sha2_rounds_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] s_i [8],
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] k,
  output logic [DATA_W-1:0] s_o [8]
);
  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction
  logic [DATA_W-1:0] s0, s1, ch, maj, t1, t2;
  always_comb begin
    s0  = rotr(s_i[0], rot_amt(DATA_W, 0)) ^ rotr(s_i[0], rot_amt(DATA_W, 1)) ^ rotr(s_i[0], rot_amt(DATA_W, 2));
    s1  = rotr(s_i[4], rot_amt(DATA_W, 3)) ^ rotr(s_i[4], rot_amt(DATA_W, 4)) ^ rotr(s_i[4], rot_amt(DATA_W, 5));
    ch  = (s_i[4] & s_i[5]) ^ (~s_i[4] & s_i[6]);
    maj = (s_i[0] & s_i[1]) ^ (s_i[0] & s_i[2]) ^ (s_i[1] & s_i[2]);
    t1  = s_i[7] + s1 + ch + k + w;
    t2  = s0 + maj;
    for (int i = 1; i < 8; i++) s_o[i] = s_i[i-1];
    s_o[0] = t1 + t2;
    s_o[4] = s_i[3] + t1;
  end
endmodule

// File: rtl/xunit_sha2_rounds.sv
// xunit_sha2_rounds: multi-round SHA-2 compression unit with optional feed-forward
//   clk, rst (async active-low), bus (slave): run/done handshake, din state/W/K, dout state, configs
module xunit_sha2_rounds import xunit_sha2_rounds_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8,
  parameter int ROUND_W = 7
) (
  input logic                clk,
  input logic                rst,
  xunit_sha2_rounds_if.slave bus
);
  if (!legal_data_w(DATA_W)) begin : g_bad_data_w
    $error("xunit_sha2_rounds: DATA_W must be 32 or 64");
  end
  state_e             state_q, state_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  st_q [8], st_d [8], h_q [8], h_d [8], nxt [8];
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [ROUND_W-1:0] rnd_q, rnd_d, rounds_q, rounds_d;
  logic               ff_q, ff_d;
  xsha2_round_comb #(.DATA_W(DATA_W)) u_round (
    .s_i(st_q),
    .w  (bus.din[8]),
    .k  (bus.din[9]),
    .s_o(nxt)
  );
  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    h_d      = h_q;
    dly_d    = dly_q;
    rnd_d    = rnd_q;
    rounds_d = rounds_q;
    ff_d     = ff_q;
    // run wins in every state and silently abandons any operation in flight
    if (bus.run) begin
      rounds_d = bus.config_rounds;
      ff_d     = bus.config_feedfwd;
      dly_d    = bus.config_delay;
      state_d  = S_WAIT;
    end else begin
      case (state_q)
        S_WAIT: begin
          dly_d   = dly_q - 1'b1;
          state_d = dly_q <= 1 ? S_LOAD : S_WAIT;
        end
        S_LOAD: begin
          for (int i = 0; i < 8; i++) begin
            st_d[i] = bus.din[i];
            h_d[i]  = bus.din[i];
          end
          rnd_d   = '0;
          state_d = rounds_q != 0 ? S_ROUND : ff_q ? S_FF : S_DONE;
        end
        S_ROUND: begin
          st_d    = nxt;
          rnd_d   = rnd_q + 1'b1;
          state_d = rnd_q == rounds_q - 1'b1 ? (ff_q ? S_FF : S_DONE) : S_ROUND;
        end
        S_FF: begin
          for (int i = 0; i < 8; i++) st_d[i] = st_q[i] + h_q[i];
          state_d = S_DONE;
        end
        default: ;
      endcase
    end
    done_d = state_d == S_IDLE || state_d == S_DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b1;
      st_q     <= '{default: '0};
      h_q      <= '{default: '0};
      dly_q    <= '0;
      rnd_q    <= '0;
      rounds_q <= '0;
      ff_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      st_q     <= st_d;
      h_q      <= h_d;
      dly_q    <= dly_d;
      rnd_q    <= rnd_d;
      rounds_q <= rounds_d;
      ff_q     <= ff_d;
    end
  end
  assign bus.dout = st_q;
  assign bus.done = done_q;
endmodule
